// File: rtl/mac9_accum_tree.sv
// mac9_accum_tree
//
// Nine-input signed multiply-accumulate reduction for the 3x3 convolution
// datapath. Each valid cycle it sums nine signed 16-bit products, a signed
// 16-bit bias and the previous saturated result scaled by 64. The result is
// scaled down by 64 with an arithmetic floor and then registered, both raw
// (14 bits) and saturated to 13 bits.
//
// The reduction is a carry-save tree. Stage 1 compresses the ten product and
// bias operands down to a sum/carry pair. Stage 2 folds in the feedback term.
// A single carry-propagate adder follows, then saturation and the output
// register.
//
// Configuration macro: MAC_SAT_EN
//   defined   : out_sat saturates to [-4096, +4095].
//   undefined : out_sat is the low 13 bits of sum_raw (wraps). The feedback
//               term then uses the wrapped value.
//
// Ports
//   clk        in   1    rising-edge clock
//   reset      in   1    synchronous, active-low reset
//   in_valid   in   1    qualifies prod/bias/acc_first this cycle
//   acc_first  in   1    first term of a group; feedback forced to zero
//   prod       in   144  nine signed 16-bit products, lane i at [16i+15:16i]
//   bias       in   16   signed bias added once per valid cycle
//   out_valid  out  1    registered in_valid
//   sum_raw    out  14   registered S[19:6], two's complement
//   out_sat    out  13   registered saturated (or wrapped) result, signed

module mac9_accum_tree (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic         acc_first,
    input  logic [143:0] prod,
    input  logic [15:0]  bias,
    output logic         out_valid,
    output logic [13:0]  sum_raw,
    output logic [12:0]  out_sat
);

    // 3:2 compressor helpers. The carry word is shifted left one place. The
    // tree is kept at the full 20-bit width throughout, so every low-order
    // carry survives into the final adder.
    function automatic logic [19:0] csa_sum(input logic [19:0] a,
                                            input logic [19:0] b,
                                            input logic [19:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [19:0] csa_carry(input logic [19:0] a,
                                              input logic [19:0] b,
                                              input logic [19:0] c);
        logic [19:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {maj[18:0], 1'b0};
    endfunction

    // Sign-extend the nine product lanes and the bias to the 20-bit tree width.
    logic [19:0] op [0:9];

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            op[i] = {{4{prod[16*i+15]}}, prod[16*i +: 16]};
        end
        op[9] = {{4{bias[15]}}, bias};
    end

    // Stage 1: reduce ten operands to a sum/carry pair (10 -> 7 -> 5 -> 4 -> 3 -> 2).
    logic [19:0] a_s0, a_c0, a_s1, a_c1, a_s2, a_c2;
    logic [19:0] b_s0, b_c0, b_s1, b_c1;
    logic [19:0] c_s0, c_c0;
    logic [19:0] d_s0, d_c0;
    logic [19:0] st1_s, st1_c;

    assign a_s0  = csa_sum  (op[0], op[1], op[2]);
    assign a_c0  = csa_carry(op[0], op[1], op[2]);
    assign a_s1  = csa_sum  (op[3], op[4], op[5]);
    assign a_c1  = csa_carry(op[3], op[4], op[5]);
    assign a_s2  = csa_sum  (op[6], op[7], op[8]);
    assign a_c2  = csa_carry(op[6], op[7], op[8]);

    assign b_s0  = csa_sum  (a_s0, a_c0, a_s1);
    assign b_c0  = csa_carry(a_s0, a_c0, a_s1);
    assign b_s1  = csa_sum  (a_c1, a_s2, a_c2);
    assign b_c1  = csa_carry(a_c1, a_s2, a_c2);

    assign c_s0  = csa_sum  (b_s0, b_c0, b_s1);
    assign c_c0  = csa_carry(b_s0, b_c0, b_s1);

    assign d_s0  = csa_sum  (c_s0, c_c0, b_c1);
    assign d_c0  = csa_carry(c_s0, c_c0, b_c1);

    assign st1_s = csa_sum  (d_s0, d_c0, op[9]);
    assign st1_c = csa_carry(d_s0, d_c0, op[9]);

    // Stage 2: feedback is the registered out_sat, scaled back up by 64. It is
    // zero at the start of a group. After a reset the register is zero, so a
    // non-first cycle that follows a reset accumulates onto zero.
    logic [12:0] feedback;
    logic [19:0] fb_term;
    logic [19:0] st2_s, st2_c;

    assign feedback = acc_first ? 13'd0 : out_sat;
    assign fb_term  = {feedback[12], feedback, 6'd0};
    assign st2_s    = csa_sum  (st1_s, st1_c, fb_term);
    assign st2_c    = csa_carry(st1_s, st1_c, fb_term);

    // Final carry-propagate adder. Scaling discards the six fraction bits.
    // Dropping them from the two's-complement word gives floor division.
    logic [19:0] total;
    logic [13:0] raw_next;
    logic [5:0]  unused_frac;

    assign total       = st2_s + st2_c;
    assign raw_next    = total[19:6];
    assign unused_frac = total[5:0];

    // The top two bits of the raw result show whether it lies outside the
    // 13-bit signed range. 01 means too large and 10 means too small.
    logic [12:0] sat_next;

`ifdef MAC_SAT_EN
    always_comb begin
        case (raw_next[13:12])
            2'b01:   sat_next = 13'h0FFF;
            2'b10:   sat_next = 13'h1000;
            default: sat_next = raw_next[12:0];
        endcase
    end
`else
    assign sat_next = raw_next[12:0];
`endif

    // Output register. The result registers load only on a valid cycle and
    // hold otherwise. out_valid follows in_valid every cycle. Reset takes
    // priority over everything else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            sum_raw   <= 14'd0;
            out_sat   <= 13'd0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_raw <= raw_next;
                out_sat <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_mac9_accum_tree.sv
// Self-checking bench for mac9_accum_tree. Directed cases come first, then
// randomised three-cycle accumulation groups built from 8x8 signed products.
// Each group is checked against an integer-arithmetic reference model.

module tb_mac9_accum_tree;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         acc_first;
    logic [143:0] prod;
    logic [15:0]  bias;
    logic         out_valid;
    logic [13:0]  sum_raw;
    logic [12:0]  out_sat;

    int total_count = 0;
    int pass_count  = 0;

    // Reference state, held as plain integers
    int  model_raw   = 0;
    int  model_sat   = 0;
    logic model_valid = 1'b0;

    mac9_accum_tree dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .acc_first (acc_first),
        .prod      (prod),
        .bias      (bias),
        .out_valid (out_valid),
        .sum_raw   (sum_raw),
        .out_sat   (out_sat)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Replicate one 16-bit value into all nine lanes
    function automatic logic [143:0] all_lanes(input logic [15:0] v);
        logic [143:0] p;
        for (int i = 0; i < 9; i++) p[16*i +: 16] = v;
        return p;
    endfunction

    // Reference model: sum the lanes and the bias, add 64 * feedback, floor-divide by 64, then clamp or wrap
    task automatic modelStep(input logic rst_n, input logic v, input logic f,
                             input logic [143:0] p, input logic [15:0] b);
        int s;
        int fb;
        int raw;
        if (!rst_n) begin
            model_raw   = 0;
            model_sat   = 0;
            model_valid = 1'b0;
        end else begin
            model_valid = v;
            if (v) begin
                fb = f ? 0 : model_sat;
                s  = 0;
                for (int i = 0; i < 9; i++) s += int'($signed(p[16*i +: 16]));
                s  += int'($signed(b));
                s  += fb * 64;
                raw = s >>> 6;
                model_raw = raw;
`ifdef MAC_SAT_EN
                if (s > 262143)       model_sat = 4095;
                else if (s < -262144) model_sat = -4096;
                else                  model_sat = raw;
`else
                model_sat = ((raw & 8191) ^ 4096) - 4096;
`endif
            end
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then advance the model past the next rising edge
    task automatic applyStimulus(input logic rst_n, input logic v, input logic f,
                                 input logic [143:0] p, input logic [15:0] b);
        @(negedge clk);
        reset     = rst_n;
        in_valid  = v;
        acc_first = f;
        prod      = p;
        bias      = b;
        @(posedge clk);
        #1;
        modelStep(rst_n, v, f, p, b);
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Compare all three outputs against the reference model
    task automatic checkOutput(input string tag);
        logic [13:0] exp_raw;
        logic [12:0] exp_sat;
        exp_raw = 14'(model_raw);
        exp_sat = 13'(model_sat);
        checkValue({tag, "_valid"}, {31'd0, out_valid}, {31'd0, model_valid});
        checkValue({tag, "_raw"},   {18'd0, sum_raw},   {18'd0, exp_raw});
        checkValue({tag, "_sat"},   {19'd0, out_sat},   {19'd0, exp_sat});
    endtask

    initial begin
        logic [143:0] rp;
        int a;
        int m;
        reset     = 1'b0;
        in_valid  = 1'b0;
        acc_first = 1'b0;
        prod      = '0;
        bias      = '0;

        // Reset held for two cycles with random inputs
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 9; i++) rp[16*i +: 16] = 16'($urandom);
            applyStimulus(1'b0, 1'b1, 1'($urandom), rp, 16'($urandom));
            checkOutput("reset");
            checkValue("reset_raw_zero", {18'd0, sum_raw}, 32'd0);
        end

        // All lanes 100: S = 900, result 14
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'd100), 16'd0);
        checkOutput("lanes100");
        checkValue("lanes100_raw_const", {18'd0, sum_raw}, 32'd14);
        checkValue("lanes100_sat_const", {19'd0, out_sat}, 32'd14);

        // All lanes -1: S = -9, floor gives -1
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'hFFFF), 16'd0);
        checkOutput("lanes_m1");
        checkValue("lanes_m1_raw_const", {18'd0, sum_raw}, 32'h3FFF);
        checkValue("lanes_m1_sat_const", {19'd0, out_sat}, 32'h1FFF);

        // Positive overflow: 2815, then S = 360383
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'd16384), 16'h7FFF);
        checkOutput("pos_first");
        checkValue("pos_first_const", {19'd0, out_sat}, 32'd2815);
        applyStimulus(1'b1, 1'b1, 1'b0, all_lanes(16'd16384), 16'h7FFF);
        checkOutput("pos_acc");
        checkValue("pos_acc_raw_const", {18'd0, sum_raw}, 32'h15FE);
`ifdef MAC_SAT_EN
        checkValue("pos_acc_sat_const", {19'd0, out_sat}, 32'h0FFF);
`else
        checkValue("pos_acc_sat_const", {19'd0, out_sat}, 32'h15FE);
`endif

        // Negative overflow: -2798, then S = -358144
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'hC080), 16'h8000);
        checkOutput("neg_first");
        checkValue("neg_first_const", {19'd0, out_sat}, 32'h1512);
        applyStimulus(1'b1, 1'b1, 1'b0, all_lanes(16'hC080), 16'h8000);
        checkOutput("neg_acc");
`ifdef MAC_SAT_EN
        checkValue("neg_acc_sat_const", {19'd0, out_sat}, 32'h1000);
`else
        checkValue("neg_acc_sat_const", {19'd0, out_sat}, 32'h0A24);
`endif

        // Group restart after overflow: lanes 0, bias 64 gives 1
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'd0), 16'd64);
        checkOutput("restart");
        checkValue("restart_const", {19'd0, out_sat}, 32'd1);

        // Hold for three cycles while the inputs churn
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 9; i++) rp[16*i +: 16] = 16'($urandom);
            applyStimulus(1'b1, 1'b0, 1'($urandom), rp, 16'($urandom));
            checkOutput("hold");
            checkValue("hold_sat_const", {19'd0, out_sat}, 32'd1);
        end

        // Reset in the middle of a group: the next non-first cycle accumulates onto zero
        applyStimulus(1'b1, 1'b1, 1'b1, all_lanes(16'd3000), 16'd0);
        checkOutput("mid_pre");
        applyStimulus(1'b0, 1'b1, 1'b0, all_lanes(16'd3000), 16'd0);
        checkOutput("mid_reset");
        applyStimulus(1'b1, 1'b1, 1'b0, all_lanes(16'd64), 16'd0);
        checkOutput("mid_post");
        checkValue("mid_post_const", {19'd0, out_sat}, 32'd9);

        // Random 8x8 signed products in three-cycle groups with occasional idle cycles
        for (int g = 0; g < 60; g++) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 9; i++) begin
                    a = int'($urandom_range(0, 255)) - 128;
                    m = int'($urandom_range(0, 255)) - 128;
                    rp[16*i +: 16] = 16'(a * m);
                end
                if ($urandom_range(0, 9) == 0) begin
                    applyStimulus(1'b1, 1'b0, 1'b1, rp, 16'($urandom));
                    checkOutput("rand_idle");
                end
                applyStimulus(1'b1, 1'b1, (k == 0), rp, 16'($urandom));
                checkOutput("rand");
            end
        end

        $display("[TB] %0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/mac9_accum_tree.md
# mac9_accum_tree

Nine-input signed multiply-accumulate reduction block for the CNN accelerator's 3×3 convolution datapath. It sums nine signed 16-bit products from the partial-product multiplier, a 16-bit bias and a scaled feedback of its own previous result. It produces a raw 14-bit result and a 13-bit saturated result for the next stage. Internally it is a carry-save adder tree (stage 1: products + bias; stage 2: + feedback) followed by a final carry-propagate adder and an output register.

## Interface
- No parameters; all widths fixed.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  qualifies prod/bias/acc_first this cycle.
- acc_first  in  1  first term of an accumulation group; feedback term forced to 0.
- prod  in  144  nine signed 16-bit products; lane i at [16i+15:16i].
- bias  in  16  signed bias added once per cycle.
- out_valid  out  1  registered in_valid.
- sum_raw  out  14  registered S[19:6], two's complement.
- out_sat  out  13  registered saturated result, signed.

One clock; reset is synchronous and active-low (ports clk, reset).

## Operation
- Feedback F (13-bit signed) = current out_sat register, or 0 when acc_first=1.
- S (20-bit signed) = Σ sign-extended prod lanes + sext(bias) + (sext(F) << 6). The worst case, ±442,000, fits in 20 bits; no internal overflow is allowed.
- Result scaling: drop the low 6 bits (arithmetic floor), so sum_raw = S[19:6].
- Saturation, from sum_raw[13:12]:
  - 01 → out_sat = 13'h0FFF (+4095).
  - 10 → out_sat = 13'h1000 (−4096).
  - Otherwise out_sat = sum_raw[12:0].
- Saturation is equivalent to S > 262143 or S < −262144.
- The tree must be bit-exact: no truncation of low-order carries before the final adder.
- Accumulation groups: the first cycle has acc_first=1; following cycles (typically 2 more, for 3 kernel rows) have acc_first=0 and accumulate onto the saturated previous result.

## Timing
- Latency 1 cycle: inputs sampled at edge k appear on sum_raw/out_sat/out_valid after edge k.
- in_valid=0: registers hold value; out_valid←0; acc_first ignored.
- Back-to-back valid cycles are supported every clock; feedback uses the value registered at the preceding edge.
- Reset (reset=0 at an edge): sum_raw=0, out_sat=0, out_valid=0. Reset overrides in_valid.
- Reset mid-group: the next non-first cycle accumulates onto 0.
- The combinational path prod→adder tree→CPA→saturation must close in one cycle.

## Configuration
- MAC_SAT_EN defined: saturation as above.
- MAC_SAT_EN undefined:
  - out_sat = sum_raw[12:0] (wrap).
  - Feedback uses the wrapped value.
  - sum_raw is unchanged.

## Test plan
- Reset: hold reset=0 two cycles with random inputs → sum_raw=0, out_sat=0, out_valid=0.
- All lanes 100, bias 0, acc_first=1 → S=900, sum_raw=14, out_sat=14.
- All lanes −1, bias 0, acc_first=1 → S=−9, sum_raw=14'h3FFF, out_sat=13'h1FFF (−1).
- Positive saturation:
  - All lanes 16384, bias 32767, acc_first=1 → out_sat=2815.
  - Same inputs next cycle with acc_first=0 → S=360383, sum_raw=14'h15FE, out_sat=4095 (wrap value 0x15FE[12:0] when MAC_SAT_EN is off).
- Negative saturation:
  - All lanes −16256, bias −32768, acc_first=1 → out_sat=−2798.
  - Next cycle with acc_first=0 → S=−358144, out_sat=−4096.
- Group restart and hold:
  - After saturation, acc_first=1 with lanes 0, bias 64 → out_sat=1.
  - in_valid=0 for 3 cycles → outputs hold, out_valid=0.
  - Random 256×256 operand sweep over 3-cycle groups matches a behavioural model exactly.
